// File: rtl/buffet_pkg.sv
// rtl/buffet_pkg.sv - shared widths, buffer size and request-queue entry type for buffet_core.
package buffet_pkg;
    localparam int IDX_W        = 8;
    localparam int DATA_W       = 32;
    localparam int RQ_DEPTH_DEF = 4;
    localparam int SIZE         = 2 ** IDX_W;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic             is_shrink;
        logic             will_update;
    } req_t;
endpackage

// File: rtl/buffet_req_fifo.sv
// rtl/buffet_req_fifo.sv - in-order read/shrink request queue; head entry visible while not empty.
module buffet_req_fifo
    import buffet_pkg::*;
#(
    parameter int DEPTH = RQ_DEPTH_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  req_t push_req,
    input  logic pop,
    output req_t head_req,
    output logic empty,
    output logic full
);
    localparam int PW = $clog2(DEPTH);

    req_t          slots [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;

    assign empty    = (count == '0);
    assign full     = (count == (PW+1)'(DEPTH));
    assign head_req = slots[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (PW+1)'(push) - (PW+1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) slots[wr_ptr] <= push_req;
    end
endmodule

// File: rtl/buffet_core.sv
// rtl/buffet_core.sv - buffet circular buffer with head-relative read/update/shrink; BUFFET_CREDIT_EN enables credits.
module buffet_core
    import buffet_pkg::*;
#(
    parameter int IDX_WIDTH  = IDX_W,
    parameter int DATA_WIDTH = DATA_W,
    parameter int RQ_DEPTH   = RQ_DEPTH_DEF
) (
    input  logic                  clk,
    input  logic                  nreset_i,
    output logic [DATA_WIDTH-1:0] read_data,
    input  logic                  read_data_ready,
    output logic                  read_data_valid,
    input  logic [IDX_WIDTH-1:0]  read_idx,
    input  logic                  read_idx_valid,
    output logic                  read_idx_ready,
    input  logic                  read_will_update,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  push_data_valid,
    output logic                  push_data_ready,
    input  logic [DATA_WIDTH-1:0] update_data,
    input  logic                  update_data_valid,
    input  logic [IDX_WIDTH-1:0]  update_idx,
    input  logic                  update_idx_valid,
    output logic                  update_ready,
    output logic                  update_receive_ack,
    input  logic                  is_shrink,
    input  logic                  credit_ready,
    output logic [IDX_WIDTH-1:0]  credit_out,
    output logic                  credit_valid
);
    localparam int DEPTH = 2 ** IDX_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [IDX_WIDTH-1:0]  head;
    logic [IDX_WIDTH:0]    occ;
    logic [DEPTH-1:0]      pending;

    req_t                  rq_in;
    req_t                  rq;
    logic                  rq_empty;
    logic                  rq_full;
    logic                  fill;
    logic                  upd;
    logic                  issue_read;
    logic                  issue_shrink;
    logic                  shrink_blocked;
    logic [IDX_WIDTH:0]    shrink_amt;
    logic [IDX_WIDTH-1:0]  rd_slot;
    logic [IDX_WIDTH-1:0]  fill_slot;
    logic [IDX_WIDTH-1:0]  upd_slot;

    assign rq_in = '{idx: read_idx, is_shrink: is_shrink, will_update: read_will_update};

    buffet_req_fifo #(.DEPTH(RQ_DEPTH)) u_req_fifo (
        .clk      (clk),
        .rst      (nreset_i),
        .push     (read_idx_valid && read_idx_ready),
        .push_req (rq_in),
        .pop      (issue_read || issue_shrink),
        .head_req (rq),
        .empty    (rq_empty),
        .full     (rq_full)
    );

    assign read_idx_ready  = !rq_full;
    assign push_data_ready = (occ < (IDX_WIDTH+1)'(DEPTH));
    assign update_ready    = 1'b1;
    assign fill            = push_data_valid && push_data_ready;
    assign upd             = update_data_valid && update_idx_valid;
    assign fill_slot       = head + occ[IDX_WIDTH-1:0];
    assign upd_slot        = head + update_idx;
    assign rd_slot         = head + rq.idx;

    // A shrink may only retire slots with no read-for-update still outstanding.
    always_comb begin
        shrink_blocked = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i < int'(rq.idx) && pending[head + IDX_WIDTH'(i)]) shrink_blocked = 1'b1;
        end
    end

    assign issue_read   = !rq_empty && !rq.is_shrink && (occ > {1'b0, rq.idx}) &&
                          !pending[rd_slot] && (!read_data_valid || read_data_ready);
    assign issue_shrink = !rq_empty && rq.is_shrink && ({1'b0, rq.idx} <= occ) && !shrink_blocked;
    assign shrink_amt   = issue_shrink ? {1'b0, rq.idx} : '0;

    always_ff @(posedge clk or posedge nreset_i) begin
        if (nreset_i) begin
            head               <= '0;
            occ                <= '0;
            pending            <= '0;
            read_data_valid    <= 1'b0;
            read_data          <= '0;
            update_receive_ack <= 1'b0;
        end else begin
            head               <= head + shrink_amt[IDX_WIDTH-1:0];
            occ                <= occ + (IDX_WIDTH+1)'(fill) - shrink_amt;
            update_receive_ack <= upd;
            if (issue_read) begin
                read_data_valid <= 1'b1;
                read_data       <= mem[rd_slot];
            end else if (read_data_ready) begin
                read_data_valid <= 1'b0;
            end
            if (upd) pending[upd_slot] <= 1'b0;
            if (issue_read && rq.will_update) pending[rd_slot] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (fill) mem[fill_slot] <= push_data;
        if (upd)  mem[upd_slot]  <= update_data;
    end

`ifdef BUFFET_CREDIT_EN
    logic [IDX_WIDTH:0] credit_count;

    assign credit_valid = (credit_count != '0);
    assign credit_out   = credit_count[IDX_WIDTH] ? '1 : credit_count[IDX_WIDTH-1:0];

    always_ff @(posedge clk or posedge nreset_i) begin
        if (nreset_i) begin
            credit_count <= (IDX_WIDTH+1)'(DEPTH);
        end else begin
            credit_count <= credit_count
                          - ((credit_valid && credit_ready) ? {1'b0, credit_out} : '0)
                          + shrink_amt;
        end
    end
`else
    logic credit_ready_unused;

    assign credit_ready_unused = credit_ready;
    assign credit_valid        = 1'b0;
    assign credit_out          = '0;
`endif
endmodule

// File: tb/tb_buffet_core.sv
// tb/tb_buffet_core.sv - scoreboard bench for buffet_core; BUFFET_CREDIT_EN selects credit expectations.
module tb_buffet_core;
    localparam int IW = 8;
    localparam int DW = 32;
    localparam int SZ = 256;
`ifdef BUFFET_CREDIT_EN
    localparam bit CREDIT_EN = 1'b1;
`else
    localparam bit CREDIT_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          nreset_i;
    logic [DW-1:0] read_data;
    logic          read_data_ready;
    logic          read_data_valid;
    logic [IW-1:0] read_idx;
    logic          read_idx_valid;
    logic          read_idx_ready;
    logic          read_will_update;
    logic [DW-1:0] push_data;
    logic          push_data_valid;
    logic          push_data_ready;
    logic [DW-1:0] update_data;
    logic          update_data_valid;
    logic [IW-1:0] update_idx;
    logic          update_idx_valid;
    logic          update_ready;
    logic          update_receive_ack;
    logic          is_shrink;
    logic          credit_ready;
    logic [IW-1:0] credit_out;
    logic          credit_valid;

    buffet_core #(.IDX_WIDTH(IW), .DATA_WIDTH(DW), .RQ_DEPTH(4)) dut (
        .clk(clk), .nreset_i(nreset_i),
        .read_data(read_data), .read_data_ready(read_data_ready), .read_data_valid(read_data_valid),
        .read_idx(read_idx), .read_idx_valid(read_idx_valid), .read_idx_ready(read_idx_ready),
        .read_will_update(read_will_update),
        .push_data(push_data), .push_data_valid(push_data_valid), .push_data_ready(push_data_ready),
        .update_data(update_data), .update_data_valid(update_data_valid),
        .update_idx(update_idx), .update_idx_valid(update_idx_valid),
        .update_ready(update_ready), .update_receive_ack(update_receive_ack),
        .is_shrink(is_shrink), .credit_ready(credit_ready),
        .credit_out(credit_out), .credit_valid(credit_valid)
    );

    always #5 clk = ~clk;

    int            compared   = 0;
    int            mismatched = 0;
    int            resp_count = 0;
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] a_word [5];
    logic [DW-1:0] c_word [4];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every valid cycle with ready high is one response to score.
    always @(negedge clk) begin
        if (!nreset_i && read_data_valid && read_data_ready) begin
            resp_count++;
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_resp: got %h expected no response", read_data);
            end else begin
                check("read_data", read_data, exp_q.pop_front());
            end
        end
    end

    task automatic push_word(input logic [DW-1:0] d);
        int n = 0;
        push_data       = d;
        push_data_valid = 1'b1;
        while (!push_data_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n == 200) check("push_timeout", 32'(push_data_ready), 32'd1);
        @(posedge clk); #1;
        push_data_valid = 1'b0;
    endtask

    task automatic send_req(input logic [IW-1:0] idx, input logic shrink, input logic wu);
        int n = 0;
        read_idx         = idx;
        is_shrink        = shrink;
        read_will_update = wu;
        read_idx_valid   = 1'b1;
        while (!read_idx_ready && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        if (n == 1000) check("req_timeout", 32'(read_idx_ready), 32'd1);
        @(posedge clk); #1;
        read_idx_valid = 1'b0;
    endtask

    task automatic do_update(input logic [IW-1:0] idx, input logic [DW-1:0] d);
        update_idx        = idx;
        update_data       = d;
        update_idx_valid  = 1'b1;
        update_data_valid = 1'b1;
        @(posedge clk); #1;
        update_idx_valid  = 1'b0;
        update_data_valid = 1'b0;
        check("ack_pulse", 32'(update_receive_ack), 32'd1);
        @(posedge clk); #1;
        check("ack_clear", 32'(update_receive_ack), 32'd0);
    endtask

    task automatic wait_resp(input int target, input string name);
        int n = 0;
        while (resp_count < target && n < 1000) begin
            @(posedge clk);
            n++;
        end
        #1;
        check(name, 32'(resp_count), 32'(target));
    endtask

    task automatic expect_stall(input string name);
        int base = resp_count;
        repeat (100) @(posedge clk);
        #1;
        check(name, 32'(resp_count - base), 32'd0);
        check({name, "_valid"}, 32'(read_data_valid), 32'd0);
    endtask

    initial begin
        nreset_i = 1'b1;
        read_data_ready = 1'b1;
        read_idx = '0; read_idx_valid = 1'b0; read_will_update = 1'b0; is_shrink = 1'b0;
        push_data = '0; push_data_valid = 1'b0;
        update_data = '0; update_data_valid = 1'b0; update_idx = '0; update_idx_valid = 1'b0;
        credit_ready = 1'b0;
        for (int i = 0; i < 5; i++) a_word[i] = 32'hA0A0_0000 + 32'(i);
        for (int i = 0; i < 4; i++) c_word[i] = 32'hC0C0_0000 + 32'(i);

        repeat (3) @(posedge clk);
        #1 nreset_i = 1'b0;
        @(negedge clk);
        check("rst_valid", 32'(read_data_valid), 32'd0);
        check("rst_data", read_data, 32'd0);
        check("rst_ack", 32'(update_receive_ack), 32'd0);
        check("rst_push_ready", 32'(push_data_ready), 32'd1);
        check("rst_idx_ready", 32'(read_idx_ready), 32'd1);
        check("rst_update_ready", 32'(update_ready), 32'd1);
        check("rst_credit_valid", 32'(credit_valid), CREDIT_EN ? 32'd1 : 32'd0);
        check("rst_credit_out", 32'(credit_out), CREDIT_EN ? 32'd255 : 32'd0);

        // Producer takes 255 of the 256 reset credits, leaving 1.
        credit_ready = 1'b1;
        @(posedge clk); #1;
        credit_ready = 1'b0;
        check("credit_after_take", 32'(credit_out), CREDIT_EN ? 32'd1 : 32'd0);

        for (int i = 0; i < 5; i++) push_word(a_word[i]);
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(a_word[i]);
            send_req(IW'(i), 1'b0, 1'b1);
        end
        wait_resp(3, "rfu_resp_count");

        exp_q.push_back(32'h5A5A_1111);
        send_req(8'd1, 1'b0, 1'b0);
        expect_stall("stall_pending_idx1");
        exp_q.push_back(a_word[4]);
        send_req(8'd4, 1'b0, 1'b0);
        expect_stall("stall_behind_idx1");
        do_update(8'd1, 32'h5A5A_1111);
        wait_resp(5, "post_update_resp_count");

        do_update(8'd0, 32'hB0B0_0000);
        do_update(8'd2, 32'hB0B0_0002);
        send_req(8'd5, 1'b1, 1'b0);
        repeat (4) @(posedge clk); #1;
        check("credit_after_shrink5", 32'(credit_out), CREDIT_EN ? 32'd6 : 32'd0);

        exp_q.push_back(c_word[3]);
        send_req(8'd3, 1'b0, 1'b0);
        expect_stall("stall_empty_idx3");
        for (int i = 0; i < 4; i++) push_word(c_word[i]);
        wait_resp(6, "fill_resp_count");

        send_req(8'd2, 1'b1, 1'b0);
        repeat (4) @(posedge clk); #1;
        check("credit_after_shrink2", 32'(credit_out), CREDIT_EN ? 32'd8 : 32'd0);
        exp_q.push_back(c_word[2]);
        send_req(8'd0, 1'b0, 1'b0);
        wait_resp(7, "shrink_read_resp_count");

        for (int k = 0; k < SZ - 2; k++) push_word(32'hD000_0000 + 32'(k));
        check("full_push_ready", 32'(push_data_ready), 32'd0);
        exp_q.push_back(32'hD000_0000 + 32'(SZ - 3));
        send_req(8'd255, 1'b0, 1'b0);
        wait_resp(8, "wrap_read_resp_count");

        send_req(8'd1, 1'b1, 1'b0);
        repeat (4) @(posedge clk); #1;
        check("after_shrink1_push_ready", 32'(push_data_ready), 32'd1);
        check("credit_after_shrink1", 32'(credit_out), CREDIT_EN ? 32'd9 : 32'd0);
        exp_q.push_back(c_word[3]);
        send_req(8'd0, 1'b0, 1'b0);
        wait_resp(9, "final_read_resp_count");

        repeat (5) @(posedge clk); #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
